// File: rtl/sevga_pkg.sv
// Shared types for the VRAM write path.
// Posted CPU writes travel as vram_wr_t bundles.
package sevga_pkg;

  localparam int VRAM_AW = 15;
  localparam logic [2:0] VRAM_WR_SLOT = 3'd6;

  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
    logic        bufSel;
  } vram_wr_t;

endpackage

// File: rtl/wrbuf_fifo.sv
// Synchronous FIFO of posted VRAM writes.
// Occupancy is a separate up/down counter.
module wrbuf_fifo
  import sevga_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic                   push,
  input  vram_wr_t               pushEntry,
  input  logic                   pop,
  output vram_wr_t               head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  vram_wr_t        mem [DEPTH];
  logic [PW-1:0]   wrPtr;
  logic [PW-1:0]   rdPtr;
  logic [LW-1:0]   cnt;
  logic            doPush;
  logic            doPop;

  assign full   = (cnt == LW'(DEPTH));
  assign empty  = (cnt == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign head   = mem[rdPtr];
  assign level  = cnt;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
      unique case ({doPush, doPop})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushEntry;
  end

endmodule

// File: rtl/vram_wrbuf.sv
// CPU posted-write buffer draining one write per
// character period into the sequencer write slot.
module vram_wrbuf
  import sevga_pkg::*;
#(
  parameter int         DEPTH   = 8,
  parameter logic [2:0] WR_SLOT = VRAM_WR_SLOT
) (
  input  logic                   pixClk,
  input  logic                   nReset,
  input  logic [2:0]             seq,
  input  logic                   inValid,
  input  logic [14:0]            inAddr,
  input  logic [7:0]             inData,
  input  logic                   inBufSel,
  output logic                   inReady,
  input  logic                   clrOvf,
  output logic [14:0]            vramAddr,
  output logic [7:0]             vramDataOut,
  output logic                   nvramWE,
  output logic                   nvramCE0,
  output logic                   nvramCE1,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf
);

  // Load on the edge before the slot so the strobe
  // spans the whole WR_SLOT cycle.
  localparam logic [2:0] POP_SLOT = WR_SLOT - 3'd1;

  vram_wr_t entry;
  vram_wr_t head;
  logic     full;
  logic     empty;
  logic     push;
  logic     pop;

  assign entry   = '{addr: inAddr, data: inData, bufSel: inBufSel};
  assign inReady = nReset & ~full;
  assign push    = inValid & inReady;
  assign pop     = (seq == POP_SLOT) & ~empty;

  wrbuf_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (pixClk),
    .nReset   (nReset),
    .push     (push),
    .pushEntry(entry),
    .pop      (pop),
    .head     (head),
    .level    (level),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge pixClk) begin
    if (!nReset) begin
      nvramWE     <= 1'b1;
      nvramCE0    <= 1'b1;
      nvramCE1    <= 1'b1;
      vramAddr    <= '0;
      vramDataOut <= '0;
    end else if (pop) begin
      nvramWE     <= 1'b0;
      nvramCE0    <= head.bufSel;
      nvramCE1    <= ~head.bufSel;
      vramAddr    <= head.addr;
      vramDataOut <= head.data;
    end else begin
      nvramWE     <= 1'b1;
      nvramCE0    <= 1'b1;
      nvramCE1    <= 1'b1;
    end
  end

  // A fresh overflow wins over a simultaneous clear.
  always_ff @(posedge pixClk) begin
    if (!nReset)                 ovf <= 1'b0;
    else if (inValid & ~inReady) ovf <= 1'b1;
    else if (clrOvf)             ovf <= 1'b0;
  end

endmodule

// File: tb/tb_vram_wrbuf.sv
// Directed bench for vram_wrbuf: cycle table plus
// hand-written overflow, reset and slot sequences.
module tb_vram_wrbuf;

  logic        pixClk = 1'b0;
  logic        nReset;
  logic [2:0]  seq;
  logic        inValid;
  logic [14:0] inAddr;
  logic [7:0]  inData;
  logic        inBufSel;
  logic        inReady;
  logic        clrOvf;
  logic [14:0] vramAddr;
  logic [7:0]  vramDataOut;
  logic        nvramWE;
  logic        nvramCE0;
  logic        nvramCE1;
  logic [3:0]  level;
  logic        ovf;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    logic        v;
    logic [14:0] a;
    logic [7:0]  d;
    logic        s;
    logic        we;
    logic        ce0;
    logic        ce1;
    logic [14:0] ea;
    logic [7:0]  ed;
    logic [3:0]  lvl;
  } vec_t;

  vec_t rows[$];

  vram_wrbuf dut (
    .pixClk     (pixClk),
    .nReset     (nReset),
    .seq        (seq),
    .inValid    (inValid),
    .inAddr     (inAddr),
    .inData     (inData),
    .inBufSel   (inBufSel),
    .inReady    (inReady),
    .clrOvf     (clrOvf),
    .vramAddr   (vramAddr),
    .vramDataOut(vramDataOut),
    .nvramWE    (nvramWE),
    .nvramCE0   (nvramCE0),
    .nvramCE1   (nvramCE1),
    .level      (level),
    .ovf        (ovf)
  );

  always #20 pixClk = ~pixClk;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixClk);
    #1;
    seq = seq + 3'd1;
  endtask

  task automatic alignTo(input logic [2:0] k);
    while (seq != k) tick();
  endtask

  task automatic drive(input logic [14:0] a,
                       input logic [7:0] d,
                       input logic s);
    inValid  = 1'b1;
    inAddr   = a;
    inData   = d;
    inBufSel = s;
  endtask

  task automatic waitStrobe(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (nvramWE !== 1'b0 && n < 16);
    check("strobe_seen", {63'd0, nvramWE}, 64'd0);
  endtask

  function automatic void addRow(
    input logic v, input logic [14:0] a,
    input logic [7:0] d, input logic s,
    input logic we, input logic ce0, input logic ce1,
    input logic [14:0] ea, input logic [7:0] ed,
    input logic [3:0] lvl);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.s = s;
    r.we = we; r.ce0 = ce0; r.ce1 = ce1;
    r.ea = ea; r.ed = ed; r.lvl = lvl;
    rows.push_back(r);
  endfunction

  initial begin
    int n;
    int strobes;

    // single push at seq 2, strobe at seq 6
    addRow(1, 15'h1A2B, 8'h5A, 0, 1, 1, 1, 15'h0, 8'h0, 4'd1);
    addRow(0, 15'h0, 8'h0, 0, 1, 1, 1, 15'h0, 8'h0, 4'd1);
    addRow(0, 15'h0, 8'h0, 0, 1, 1, 1, 15'h0, 8'h0, 4'd1);
    addRow(0, 15'h0, 8'h0, 0, 0, 0, 1, 15'h1A2B, 8'h5A, 4'd0);
    addRow(0, 15'h0, 8'h0, 0, 1, 1, 1, 15'h1A2B, 8'h5A, 4'd0);
    // three back-to-back pushes, sel 1,0,1
    addRow(1, 15'h0100, 8'h11, 1, 1, 1, 1, 15'h1A2B, 8'h5A, 4'd1);
    addRow(1, 15'h0200, 8'h22, 0, 1, 1, 1, 15'h1A2B, 8'h5A, 4'd2);
    addRow(1, 15'h0300, 8'h33, 1, 1, 1, 1, 15'h1A2B, 8'h5A, 4'd3);
    repeat (3)
      addRow(0, 15'h0, 8'h0, 0, 1, 1, 1, 15'h1A2B, 8'h5A, 4'd3);
    addRow(0, 15'h0, 8'h0, 0, 0, 1, 0, 15'h0100, 8'h11, 4'd2);
    repeat (7)
      addRow(0, 15'h0, 8'h0, 0, 1, 1, 1, 15'h0100, 8'h11, 4'd2);
    addRow(0, 15'h0, 8'h0, 0, 0, 0, 1, 15'h0200, 8'h22, 4'd1);
    repeat (7)
      addRow(0, 15'h0, 8'h0, 0, 1, 1, 1, 15'h0200, 8'h22, 4'd1);
    addRow(0, 15'h0, 8'h0, 0, 0, 1, 0, 15'h0300, 8'h33, 4'd0);
    addRow(0, 15'h0, 8'h0, 0, 1, 1, 1, 15'h0300, 8'h33, 4'd0);

    nReset = 1'b0; seq = 3'd0;
    inValid = 1'b0; inAddr = '0; inData = '0;
    inBufSel = 1'b0; clrOvf = 1'b0;
    tick();
    tick();
    check("reset_state",
          {nvramWE, nvramCE0, nvramCE1, vramAddr,
           vramDataOut, level, ovf, inReady},
          {1'b1, 1'b1, 1'b1, 15'h0, 8'h0, 4'd0, 1'b0, 1'b0});
    nReset = 1'b1;
    #1;
    check("ready_after_reset", {63'd0, inReady}, 64'd1);

    alignTo(3'd2);
    for (int i = 0; i < rows.size(); i++) begin
      inValid  = rows[i].v;
      inAddr   = rows[i].a;
      inData   = rows[i].d;
      inBufSel = rows[i].s;
      tick();
      check($sformatf("row%0d", i),
            {nvramWE, nvramCE0, nvramCE1, vramAddr,
             vramDataOut, level},
            {rows[i].we, rows[i].ce0, rows[i].ce1,
             rows[i].ea, rows[i].ed, rows[i].lvl});
    end
    inValid = 1'b0;

    // fill to 8, offer a 9th while full
    alignTo(3'd5);
    for (int i = 0; i < 8; i++) begin
      drive(15'h4000 + 15'(i), 8'h80 + 8'(i), i[0]);
      tick();
    end
    inValid = 1'b0;
    #1;
    check("full_level", {60'd0, level}, 64'd8);
    check("full_ready", {63'd0, inReady}, 64'd0);
    drive(15'h7FFF, 8'hEE, 1'b1);
    tick();
    inValid = 1'b0;
    check("ovf_set", {63'd0, ovf}, 64'd1);
    check("ovf_first",
          {nvramWE, nvramCE0, nvramCE1, vramAddr,
           vramDataOut, level},
          {1'b0, 1'b0, 1'b1, 15'h4000, 8'h80, 4'd7});
    for (int i = 1; i < 8; i++) begin
      waitStrobe(n);
      check($sformatf("fill_gap%0d", i), 64'(n), 64'd8);
      check($sformatf("fill_entry%0d", i),
            {vramAddr, vramDataOut, nvramCE0, nvramCE1},
            {15'h4000 + 15'(i), 8'h80 + 8'(i),
             i[0], ~i[0]});
    end
    strobes = 0;
    repeat (10) begin
      tick();
      if (nvramWE == 1'b0) strobes++;
    end
    check("ninth_dropped", 64'(strobes), 64'd0);
    check("drain_level", {60'd0, level}, 64'd0);
    check("ovf_sticky", {63'd0, ovf}, 64'd1);
    clrOvf = 1'b1;
    tick();
    clrOvf = 1'b0;
    check("ovf_clear", {63'd0, ovf}, 64'd0);

    // push on the pop edge at level 4
    alignTo(3'd6);
    for (int i = 0; i < 4; i++) begin
      drive(15'h5000 + 15'(i), 8'hA0 + 8'(i), i[0]);
      tick();
    end
    inValid = 1'b0;
    tick(); tick(); tick();
    check("pp_level_before", {60'd0, level}, 64'd4);
    drive(15'h5004, 8'hA4, 1'b0);
    tick();
    inValid = 1'b0;
    check("pp_level_after", {60'd0, level}, 64'd4);
    check("pp_first",
          {nvramWE, vramAddr, vramDataOut},
          {1'b0, 15'h5000, 8'hA0});
    for (int i = 1; i < 5; i++) begin
      waitStrobe(n);
      check($sformatf("pp_entry%0d", i),
            {vramAddr, vramDataOut, nvramCE0, nvramCE1},
            {15'h5000 + 15'(i), 8'hA0 + 8'(i),
             i[0], ~i[0]});
    end
    check("pp_empty", {60'd0, level}, 64'd0);

    // reset during a strobe with five queued
    alignTo(3'd6);
    for (int i = 0; i < 6; i++) begin
      drive(15'h6000 + 15'(i), 8'h60 + 8'(i), 1'b0);
      tick();
    end
    inValid = 1'b0;
    tick(); tick();
    check("rst_pre",
          {nvramWE, level}, {1'b0, 4'd5});
    nReset = 1'b0;
    tick();
    check("rst_mid_strobe",
          {nvramWE, nvramCE0, nvramCE1, vramAddr,
           vramDataOut, level, ovf, inReady},
          {1'b1, 1'b1, 1'b1, 15'h0, 8'h0, 4'd0, 1'b0, 1'b0});
    nReset = 1'b1;
    strobes = 0;
    repeat (16) begin
      tick();
      if (nvramWE == 1'b0) strobes++;
    end
    check("rst_discard", 64'(strobes), 64'd0);

    // push during the slot itself waits a full period
    alignTo(3'd6);
    drive(15'h7ABC, 8'hC3, 1'b1);
    tick();
    inValid = 1'b0;
    check("slot_push_idle",
          {nvramWE, level}, {1'b1, 4'd1});
    waitStrobe(n);
    check("slot_latency", 64'(n + 1), 64'd8);
    check("slot_entry",
          {vramAddr, vramDataOut, nvramCE0, nvramCE1, seq},
          {15'h7ABC, 8'hC3, 1'b1, 1'b0, 3'd6});
    tick();
    check("slot_release",
          {nvramWE, nvramCE0, nvramCE1, level},
          {1'b1, 1'b1, 1'b1, 4'd0});

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
